fu_issue_port: RTL and testbench
================================

# fu_issue_port

Scheduler-side issue port for one multicycle floating-point functional unit (FMUL/FMA class). It accepts selected uops from the scheduler into a 2-entry holding queue. The head uop drives the unit's `Port_Valid`/`Port_S2E` inputs, and the port retires the head when the unit signals `Ready`. Queued uops are pruned on branch kill and flush, and their kill masks are updated on branch resolution, so the unit only ever sees live uops.

## Interface
- `S2E_LEN`, default `` `PORT_S2E_LEN ``: width of one issued uop packet.
- `SPEC_STATES`, default `` `SPEC_STATES ``: width of the kill mask.
- `DEPTH`, default 2: queue entries. Fixed at 2; any other value is unsupported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `Flush`  in  1  pipeline flush; clears all entries.
- `Kill_Enable`  in  1  branch-mispredict kill strobe.
- `Kill_VKillMask`  in  SPEC_STATES  speculative states being killed.
- `Resolve_Enable`  in  1  branch-correct strobe.
- `Resolve_Mask`  in  SPEC_STATES  kill-mask bits to clear.
- `Issue_Valid`  in  1  scheduler offers a uop.
- `Issue_Uop`  in  S2E_LEN  offered uop; its kill mask is at `` `PORT_S2E_KILLMASK ``.
- `Issue_Ready`  out  1  queue can accept a uop this cycle.
- `Port_Valid`  out  1  head entry is valid.
- `Port_S2E`  out  S2E_LEN  head uop packet.
- `Ready`  in  1  unit ready or completing; combinational from the unit.
- `Occupancy`  out  2  number of valid entries (0–2).

## Operation
- **Storage.** Two entries, `e0` (head) and `e1`, each holding a valid bit and a packet. `e1` is never valid while `e0` is invalid.
- **Push.** A push occurs when `Issue_Valid & Issue_Ready`.
  - `Issue_Ready = (Occupancy < 2)`, computed from registered state only.
  - There is no ready-through-pop, even when a pop happens in the same cycle.
  - The push writes to the lowest free slot after this cycle's pop and kills are applied.
- **Pop.** A pop occurs when `Port_Valid & Ready`. `e1` shifts to `e0`.
- **Kill.** Per entry, and also for the incoming uop: `killed = Kill_Enable & |(mask & Kill_VKillMask)`.
  - Killed entries are invalidated at the edge.
  - A surviving `e1` compacts into `e0`.
  - A killed incoming uop is not written, although `Issue_Ready` still counts it as accepted.
- **Resolve.** When `Resolve_Enable` is high, `mask &= ~Resolve_Mask` in both entries and in the incoming uop before it is written.
  - If Kill and Resolve are asserted in the same cycle, the kill is evaluated on the pre-resolve mask.
- **Flush.** `Flush` invalidates both entries and blocks any push that cycle. It has priority over push, pop and resolve.
- **Head presentation.**
  - `Port_S2E` = `e0` packet, with the same-cycle kill and resolve not yet applied.
  - `Port_Valid` = `e0` valid, unmasked. The unit applies the same kill terms itself.
  - While `Port_Valid` is 0, `Port_S2E` is driven to 0.
- **Packet integrity.** Packet contents are never modified, except the kill-mask field on resolve.

## Timing
- **Reset.** While `rst_n` = 0 at an edge, both entries are cleared. After reset:
  - `Port_Valid` = 0, `Port_S2E` = 0, `Occupancy` = 0, `Issue_Ready` = 1.
- **Latency.** Issue accepted at edge N gives `Port_Valid` = 1 from cycle N+1. There is no bypass from issue to port.
- **Back-to-back operation.**
  - The unit holds `Ready` = 0 for k-1 cycles and then raises it for one cycle.
  - `e1` is presented in the cycle after the pop, so the unit sees a continuous `Port_Valid`.
  - Sustained throughput is one uop per unit latency.
- **Mid-operation kill.** If the head is killed mid-operation, it is dropped at that edge, and the unit's counter resets on the same edge. `e1`, if live, is presented the next cycle.
- **Push, pop and kill together** resolve in this order: kill/resolve, then pop, then compact, then push.
- **Pop and push when `Occupancy` = 2.** The pop occurs; the push cannot, because `Issue_Ready` = 0.
- **Reset mid-operation.** The queue empties and `Port_Valid` falls in the next cycle.

## Test plan
- **Basic SP multiply.** Reset, then issue one SP multiply at cycle 1 with FMUL SP latency 2.
  - Cycle 2: `Port_Valid` = 1, `Ready` = 0.
  - Cycle 3: `Ready` = 1, pop.
  - Cycle 4: `Port_Valid` = 0, `Occupancy` = 0.
- **Queue fill.** Issue uops A, B, C on consecutive cycles against a 3-cycle unit.
  - A and B are accepted; `Issue_Ready` = 0 on C's cycle.
  - B is presented on the cycle after A pops; C is accepted once `Occupancy` = 1.
- **Kill head only.** Head has mask 4'b0010, `e1` has 4'b0000; pulse `Kill_Enable` with `Kill_VKillMask` = 4'b0010.
  - Next cycle: `e1`'s packet is on `Port_S2E` and `Occupancy` = 1.
- **Kill incoming, resolve stored.** Incoming uop has mask 4'b0100 and is killed in the same cycle as it is issued, so it is not stored. A separate `Resolve_Mask` = 4'b0001 clears that bit in a stored mask of 4'b0011, leaving 4'b0010.
- **Flush and simultaneous issue.** `Flush` with `Occupancy` = 2 and a simultaneous `Issue_Valid` gives `Occupancy` = 0 and `Port_Valid` = 0 on the next cycle.
- **Reset during multicycle op.** Assert `rst_n` = 0 while the head is mid-FMA.
  - All outputs take their reset values.
  - A new issue afterwards is presented with fresh timing.

Source files
------------

// File: rtl/fu_issue_port_if.sv
// Issue-port bundle: scheduler offer, kill/resolve broadcast, and unit-facing head.
`ifndef PORT_S2E_LEN
`define PORT_S2E_LEN 32
`endif
`ifndef SPEC_STATES
`define SPEC_STATES 4
`endif
`ifndef PORT_S2E_KILLMASK
`define PORT_S2E_KILLMASK 7:4
`endif

interface fu_issue_port_if #(
  parameter int unsigned S2E_LEN     = `PORT_S2E_LEN,
  parameter int unsigned SPEC_STATES = `SPEC_STATES
);
  logic                   Flush;
  logic                   Kill_Enable;
  logic [SPEC_STATES-1:0] Kill_VKillMask;
  logic                   Resolve_Enable;
  logic [SPEC_STATES-1:0] Resolve_Mask;
  logic                   Issue_Valid;
  logic [S2E_LEN-1:0]     Issue_Uop;
  logic                   Issue_Ready;
  logic                   Port_Valid;
  logic [S2E_LEN-1:0]     Port_S2E;
  logic                   Ready;
  logic [1:0]             Occupancy;

  // Scheduler / functional-unit side.
  modport master (
    output Flush, Kill_Enable, Kill_VKillMask, Resolve_Enable, Resolve_Mask,
    output Issue_Valid, Issue_Uop, Ready,
    input  Issue_Ready, Port_Valid, Port_S2E, Occupancy
  );

  // Issue port side.
  modport slave (
    input  Flush, Kill_Enable, Kill_VKillMask, Resolve_Enable, Resolve_Mask,
    input  Issue_Valid, Issue_Uop, Ready,
    output Issue_Ready, Port_Valid, Port_S2E, Occupancy
  );
endinterface

// File: rtl/fu_issue_port.sv
// Two-entry holding queue in front of one multicycle FP unit. The head drives the unit;
// queued uops are pruned on kill/flush and have their kill masks trimmed on resolve.
`ifndef PORT_S2E_LEN
`define PORT_S2E_LEN 32
`endif
`ifndef SPEC_STATES
`define SPEC_STATES 4
`endif
`ifndef PORT_S2E_KILLMASK
`define PORT_S2E_KILLMASK 7:4
`endif

module fu_issue_port #(
  parameter int unsigned S2E_LEN     = `PORT_S2E_LEN,
  parameter int unsigned SPEC_STATES = `SPEC_STATES,
  parameter int unsigned DEPTH       = 2  // only 2 is supported
) (
  input logic            clk,
  input logic            rst_n,
  fu_issue_port_if.slave io
);

  typedef logic [S2E_LEN-1:0]     pkt_t;
  typedef logic [SPEC_STATES-1:0] mask_t;

  localparam logic [1:0] Full = 2'(DEPTH);

  logic v0_q, v0_d, v1_q, v1_d;
  pkt_t p0_q, p0_d, p1_q, p1_d;

  logic kill0, kill1, kill_in;
  logic pop, push, live0, live1;
  pkt_t r0, r1, r_in;
  logic [1:0] occ;

  function automatic logic is_killed(input pkt_t p, input logic en, input mask_t vmask);
    return en & (|(p[`PORT_S2E_KILLMASK] & vmask));
  endfunction

  function automatic pkt_t resolve(input pkt_t p, input logic en, input mask_t rmask);
    pkt_t r;
    r = p;
    if (en) r[`PORT_S2E_KILLMASK] = p[`PORT_S2E_KILLMASK] & ~rmask;
    return r;
  endfunction

  // Kill is judged on the pre-resolve mask; resolve only trims what gets stored.
  assign kill0   = is_killed(p0_q, io.Kill_Enable, io.Kill_VKillMask);
  assign kill1   = is_killed(p1_q, io.Kill_Enable, io.Kill_VKillMask);
  assign kill_in = is_killed(io.Issue_Uop, io.Kill_Enable, io.Kill_VKillMask);
  assign r0      = resolve(p0_q, io.Resolve_Enable, io.Resolve_Mask);
  assign r1      = resolve(p1_q, io.Resolve_Enable, io.Resolve_Mask);
  assign r_in    = resolve(io.Issue_Uop, io.Resolve_Enable, io.Resolve_Mask);

  assign occ         = {1'b0, v0_q} + {1'b0, v1_q};
  assign io.Occupancy   = occ;
  // No ready-through-pop: acceptance depends on registered occupancy only.
  assign io.Issue_Ready = (occ < Full);
  assign io.Port_Valid  = v0_q;
  assign io.Port_S2E    = v0_q ? p0_q : '0;

  assign pop   = v0_q & io.Ready;
  assign live0 = v0_q & ~kill0 & ~pop;
  assign live1 = v1_q & ~kill1;
  // An accepted-but-killed uop is consumed without being written.
  assign push  = io.Issue_Valid & io.Issue_Ready & ~kill_in & ~io.Flush;

  // Next state: kill/resolve, pop, compact survivors toward e0, then push.
  always_comb begin
    v0_d = 1'b0;
    v1_d = 1'b0;
    p0_d = p0_q;
    p1_d = p1_q;
    if (live0) begin
      v0_d = 1'b1;
      p0_d = r0;
      v1_d = live1;
      p1_d = r1;
    end else if (live1) begin
      v0_d = 1'b1;
      p0_d = r1;
    end
    if (push) begin
      if (!v0_d) begin
        v0_d = 1'b1;
        p0_d = r_in;
      end else begin
        v1_d = 1'b1;
        p1_d = r_in;
      end
    end
    if (io.Flush) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end
  end

  // Queue state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      p0_q <= '0;
      p1_q <= '0;
    end else begin
      v0_q <= v0_d;
      v1_q <= v1_d;
      p0_q <= p0_d;
      p1_q <= p1_d;
    end
  end

endmodule

// File: tb/tb_fu_issue_port.sv
// Directed bench for fu_issue_port with a pop-order scoreboard.
`ifndef PORT_S2E_LEN
`define PORT_S2E_LEN 32
`endif
`ifndef SPEC_STATES
`define SPEC_STATES 4
`endif
`ifndef PORT_S2E_KILLMASK
`define PORT_S2E_KILLMASK 7:4
`endif

module tb_fu_issue_port;
  localparam int unsigned W = `PORT_S2E_LEN;
  localparam int unsigned S = `SPEC_STATES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fu_issue_port_if #(.S2E_LEN(W), .SPEC_STATES(S)) bus ();

  fu_issue_port #(.S2E_LEN(W), .SPEC_STATES(S), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, then clear the per-cycle strobes.
  task automatic cyc(input logic iv, input logic [W-1:0] u, input logic rdy);
    bus.Issue_Valid = iv;
    bus.Issue_Uop   = u;
    bus.Ready       = rdy;
    tick();
    bus.Flush          = 1'b0;
    bus.Kill_Enable    = 1'b0;
    bus.Kill_VKillMask = '0;
    bus.Resolve_Enable = 1'b0;
    bus.Resolve_Mask   = '0;
  endtask

  // Monitor: every retiring head (live, not flushed) must match the scoreboard front.
  always @(negedge clk) begin
    logic [W-1:0] want;
    logic [S-1:0] hmask;
    hmask = bus.Port_S2E[`PORT_S2E_KILLMASK];
    if (rst_n && !bus.Flush && bus.Port_Valid && bus.Ready &&
        !(bus.Kill_Enable && |(hmask & bus.Kill_VKillMask))) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got %0h, required no pop", bus.Port_S2E);
      end else begin
        want = exp_q.pop_front();
        if (bus.Port_S2E !== want) begin
          n_fail++;
          $display("FAIL pop_data: got %0h, required %0h", bus.Port_S2E, want);
        end
      end
    end
  end

  initial begin
    bus.Flush          = 1'b0;
    bus.Kill_Enable    = 1'b0;
    bus.Kill_VKillMask = '0;
    bus.Resolve_Enable = 1'b0;
    bus.Resolve_Mask   = '0;
    bus.Issue_Valid    = 1'b0;
    bus.Issue_Uop      = '0;
    bus.Ready          = 1'b0;

    // Reset
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_port_valid", 64'(bus.Port_Valid), 64'd0);
    chk("rst_port_s2e", 64'(bus.Port_S2E), 64'd0);
    chk("rst_occupancy", 64'(bus.Occupancy), 64'd0);
    chk("rst_issue_ready", 64'(bus.Issue_Ready), 64'd1);

    // Basic SP multiply, latency 2
    exp_q.push_back(32'h1000_0001);
    cyc(1'b1, 32'h1000_0001, 1'b0);
    chk("basic_valid", 64'(bus.Port_Valid), 64'd1);
    chk("basic_occ", 64'(bus.Occupancy), 64'd1);
    chk("basic_s2e", 64'(bus.Port_S2E), 64'h1000_0001);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    chk("basic_valid_after", 64'(bus.Port_Valid), 64'd0);
    chk("basic_occ_after", 64'(bus.Occupancy), 64'd0);

    // Queue fill against a 3-cycle unit
    exp_q.push_back(32'h2A00_0000);
    exp_q.push_back(32'h2B00_0000);
    exp_q.push_back(32'h2C00_0000);
    cyc(1'b1, 32'h2A00_0000, 1'b0);
    chk("fill_ready_b", 64'(bus.Issue_Ready), 64'd1);
    cyc(1'b1, 32'h2B00_0000, 1'b0);
    chk("fill_occ2", 64'(bus.Occupancy), 64'd2);
    chk("fill_ready_c", 64'(bus.Issue_Ready), 64'd0);
    cyc(1'b1, 32'h2C00_0000, 1'b0);
    cyc(1'b1, 32'h2C00_0000, 1'b1);
    chk("fill_b_head", 64'(bus.Port_S2E), 64'h2B00_0000);
    chk("fill_occ_after_pop", 64'(bus.Occupancy), 64'd1);
    chk("fill_ready_c2", 64'(bus.Issue_Ready), 64'd1);
    cyc(1'b1, 32'h2C00_0000, 1'b0);
    chk("fill_c_in", 64'(bus.Occupancy), 64'd2);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    chk("fill_c_head", 64'(bus.Port_S2E), 64'h2C00_0000);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    chk("fill_empty", 64'(bus.Occupancy), 64'd0);

    // Kill head only
    exp_q.push_back(32'h3100_0000);
    cyc(1'b1, 32'h3000_0020, 1'b0);
    cyc(1'b1, 32'h3100_0000, 1'b0);
    chk("killh_occ2", 64'(bus.Occupancy), 64'd2);
    bus.Kill_Enable    = 1'b1;
    bus.Kill_VKillMask = 4'b0010;
    cyc(1'b0, '0, 1'b0);
    chk("killh_s2e", 64'(bus.Port_S2E), 64'h3100_0000);
    chk("killh_occ", 64'(bus.Occupancy), 64'd1);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    chk("killh_empty", 64'(bus.Occupancy), 64'd0);

    // Kill incoming, resolve stored and incoming
    exp_q.push_back(32'h4000_0020);
    exp_q.push_back(32'h4200_0020);
    cyc(1'b1, 32'h4000_0030, 1'b0);
    bus.Kill_Enable    = 1'b1;
    bus.Kill_VKillMask = 4'b0100;
    cyc(1'b1, 32'h4100_0040, 1'b0);
    chk("killin_occ", 64'(bus.Occupancy), 64'd1);
    chk("killin_head", 64'(bus.Port_S2E), 64'h4000_0030);
    bus.Resolve_Enable = 1'b1;
    bus.Resolve_Mask   = 4'b0001;
    cyc(1'b1, 32'h4200_0030, 1'b0);
    chk("resolve_head", 64'(bus.Port_S2E), 64'h4000_0020);
    chk("resolve_occ", 64'(bus.Occupancy), 64'd2);
    cyc(1'b0, '0, 1'b1);
    chk("resolve_in_head", 64'(bus.Port_S2E), 64'h4200_0020);
    cyc(1'b0, '0, 1'b1);
    chk("resolve_empty", 64'(bus.Occupancy), 64'd0);

    // Kill and resolve together: kill sees the pre-resolve mask
    cyc(1'b1, 32'h5000_0030, 1'b0);
    bus.Kill_Enable    = 1'b1;
    bus.Kill_VKillMask = 4'b0001;
    bus.Resolve_Enable = 1'b1;
    bus.Resolve_Mask   = 4'b0001;
    cyc(1'b0, '0, 1'b0);
    chk("killres_occ", 64'(bus.Occupancy), 64'd0);
    chk("killres_valid", 64'(bus.Port_Valid), 64'd0);

    // Flush with full queue and simultaneous issue
    cyc(1'b1, 32'h6000_0000, 1'b0);
    cyc(1'b1, 32'h6100_0000, 1'b0);
    chk("flush_occ2", 64'(bus.Occupancy), 64'd2);
    bus.Flush = 1'b1;
    cyc(1'b1, 32'h6200_0000, 1'b1);
    chk("flush_occ", 64'(bus.Occupancy), 64'd0);
    chk("flush_valid", 64'(bus.Port_Valid), 64'd0);
    chk("flush_s2e", 64'(bus.Port_S2E), 64'd0);
    // Flush with room for the push: push still blocked
    cyc(1'b1, 32'h6300_0000, 1'b0);
    chk("flush1_occ1", 64'(bus.Occupancy), 64'd1);
    bus.Flush = 1'b1;
    cyc(1'b1, 32'h6400_0000, 1'b0);
    chk("flush1_occ", 64'(bus.Occupancy), 64'd0);

    // Reset during multicycle op
    cyc(1'b1, 32'h7000_0000, 1'b0);
    cyc(1'b0, '0, 1'b0);
    rst_n = 1'b0;
    cyc(1'b0, '0, 1'b0);
    rst_n = 1'b1;
    chk("rst2_valid", 64'(bus.Port_Valid), 64'd0);
    chk("rst2_s2e", 64'(bus.Port_S2E), 64'd0);
    chk("rst2_occ", 64'(bus.Occupancy), 64'd0);
    chk("rst2_ready", 64'(bus.Issue_Ready), 64'd1);
    exp_q.push_back(32'h7100_0000);
    cyc(1'b1, 32'h7100_0000, 1'b0);
    chk("rst2_new_valid", 64'(bus.Port_Valid), 64'd1);
    chk("rst2_new_s2e", 64'(bus.Port_S2E), 64'h7100_0000);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    chk("rst2_empty", 64'(bus.Occupancy), 64'd0);

    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
